// File: rtl/control_multicycle_fsm_pkg.sv
// Shared encodings for the multicycle controller: state codes, ALU controls,
// instruction op field and data-processing cmd values.
package control_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  // Flat state constants used by the state register and decode.
  localparam logic [3:0] S_FETCH    = FETCH;
  localparam logic [3:0] S_DECODE   = DECODE;
  localparam logic [3:0] S_MEMADR   = MEMADR;
  localparam logic [3:0] S_MEMREAD  = MEMREAD;
  localparam logic [3:0] S_MEMWB    = MEMWB;
  localparam logic [3:0] S_MEMWRITE = MEMWRITE;
  localparam logic [3:0] S_EXECR    = EXECR;
  localparam logic [3:0] S_EXECI    = EXECI;
  localparam logic [3:0] S_ALUWB    = ALUWB;
  localparam logic [3:0] S_BRANCH   = BRANCH;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

endpackage

// File: rtl/control_multicycle_fsm_if.sv
// Controller <-> datapath bundle. master = controller (consumes IR fields,
// drives strobes and selects); slave = datapath. All signals are level,
// sampled on the rising clk edge; there is no valid/ready pair.
interface control_multicycle_fsm_if;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       pcs;
  logic       regw;
  logic       memw;
  logic [1:0] flagw;
  logic       nextpc;
  logic       irwrite;
  logic       adrsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] resultsrc;
  logic [1:0] alucontrol;
  logic [1:0] immsrc;
  logic [1:0] regsrc;
  logic [3:0] state;

  modport master (
    input  op, funct, rd,
    output pcs, regw, memw, flagw, nextpc, irwrite, adrsrc, alusrca,
           alusrcb, resultsrc, alucontrol, immsrc, regsrc, state
  );

  modport slave (
    output op, funct, rd,
    input  pcs, regw, memw, flagw, nextpc, irwrite, adrsrc, alusrca,
           alusrcb, resultsrc, alucontrol, immsrc, regsrc, state
  );
endinterface

// File: rtl/control_multicycle_fsm_alu_decoder.sv
// Data-processing decode: cmd + S bit -> ALU control, flag-write enables and
// the CMP no-write flag. Forces ADD with no flag writes when aluop is low.
module control_alu_decoder
  import control_pkg::*;
(
  input  logic       aluop,
  input  logic [4:0] cmd_s,
  output logic [1:0] alucontrol,
  output logic [1:0] flagw,
  output logic       nowrite
);
  logic       s_bit;
  logic [3:0] cmd;

  assign s_bit = cmd_s[0];
  assign cmd   = cmd_s[4:1];

  always_comb begin
    alucontrol = ALU_ADD;
    flagw      = 2'b00;
    nowrite    = 1'b0;
    if (aluop) begin
      case (cmd)
        CMD_ADD: begin
          alucontrol = ALU_ADD;
          flagw      = {s_bit, s_bit};
        end
        CMD_SUB: begin
          alucontrol = ALU_SUB;
          flagw      = {s_bit, s_bit};
        end
        CMD_AND: begin
          alucontrol = ALU_AND;
          flagw      = {s_bit, 1'b0};
        end
        CMD_ORR: begin
          alucontrol = ALU_ORR;
          flagw      = {s_bit, 1'b0};
        end
        // CMP always updates all flags and never writes the register file.
        CMD_CMP: begin
          alucontrol = ALU_SUB;
          flagw      = 2'b11;
          nowrite    = 1'b1;
        end
        default: begin
          alucontrol = ALU_ADD;
          flagw      = 2'b00;
        end
      endcase
    end
  end
endmodule

// File: rtl/control_multicycle_fsm.sv
// Multicycle ARM-subset main controller: state register, next-state logic and
// Moore output decode; strobes are held low while rst is asserted.
module control_multicycle_fsm
  import control_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  control_multicycle_fsm_if.master       ctl
);
  logic [3:0] state;
  logic [3:0] state_nxt;
  logic       aluop;
  logic [1:0] dec_alucontrol;
  logic [1:0] dec_flagw;
  logic       dec_nowrite;
  logic       regw_raw;
  logic       memw_raw;
  logic       pcs_raw;
  logic       irwrite_raw;
  logic       nextpc_raw;

  assign aluop = (state == S_EXECR) || (state == S_EXECI);

  control_alu_decoder u_alu_dec (
    .aluop      (aluop),
    .cmd_s      (ctl.funct[4:0]),
    .alucontrol (dec_alucontrol),
    .flagw      (dec_flagw),
    .nowrite    (dec_nowrite)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (ctl.op)
          OP_MEM:  state_nxt = S_MEMADR;
          OP_DP:   state_nxt = ctl.funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   state_nxt = S_BRANCH;
          OP_UND:  state_nxt = S_FETCH;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR:         state_nxt = ctl.funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:        state_nxt = S_MEMWB;
      S_EXECR, S_EXECI: state_nxt = dec_nowrite ? S_FETCH : S_ALUWB;
      default:          state_nxt = S_FETCH;
    endcase
  end

  // Datapath selects; unlisted states leave them at the zero encoding.
  always_comb begin
    ctl.adrsrc    = 1'b0;
    ctl.alusrca   = 1'b0;
    ctl.alusrcb   = 2'b00;
    ctl.resultsrc = 2'b00;
    irwrite_raw   = 1'b0;
    nextpc_raw    = 1'b0;
    regw_raw      = 1'b0;
    memw_raw      = 1'b0;
    case (state)
      S_FETCH: begin
        irwrite_raw   = 1'b1;
        nextpc_raw    = 1'b1;
        ctl.alusrca   = 1'b1;
        ctl.alusrcb   = 2'b10;
        ctl.resultsrc = 2'b10;
      end
      S_DECODE: begin
        ctl.alusrca   = 1'b1;
        ctl.alusrcb   = 2'b10;
        ctl.resultsrc = 2'b10;
      end
      S_MEMADR:  ctl.alusrcb = 2'b01;
      S_MEMREAD: ctl.adrsrc  = 1'b1;
      S_MEMWB: begin
        ctl.resultsrc = 2'b01;
        regw_raw      = 1'b1;
      end
      S_MEMWRITE: begin
        ctl.adrsrc = 1'b1;
        memw_raw   = 1'b1;
      end
      S_EXECR:  ctl.alusrcb = 2'b00;
      S_EXECI:  ctl.alusrcb = 2'b01;
      S_ALUWB:  regw_raw    = 1'b1;
      S_BRANCH: begin
        ctl.alusrcb   = 2'b01;
        ctl.resultsrc = 2'b10;
      end
      default: ;
    endcase
  end

  // A register write to r15 redirects the PC just like a branch.
  assign pcs_raw = (state == S_BRANCH) || (regw_raw && (ctl.rd == 4'd15));

  assign ctl.irwrite    = irwrite_raw & ~rst;
  assign ctl.nextpc     = nextpc_raw & ~rst;
  assign ctl.regw       = regw_raw & ~rst;
  assign ctl.memw       = memw_raw & ~rst;
  assign ctl.pcs        = pcs_raw & ~rst;
  assign ctl.flagw      = rst ? 2'b00 : dec_flagw;
  assign ctl.alucontrol = dec_alucontrol;
  assign ctl.immsrc     = ctl.op;
  assign ctl.regsrc     = {ctl.op == OP_MEM, ctl.op == OP_BR};
  assign ctl.state      = state;
endmodule

// File: tb/tb_control_multicycle_fsm.sv
// Directed test of the multicycle controller: the driver pushes hand-computed
// per-cycle output vectors, a negedge monitor pops and compares them.
module tb_control_multicycle_fsm;
  localparam int W = 23;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  control_multicycle_fsm_if ctl_if ();

  control_multicycle_fsm dut (
    .clk (clk),
    .rst (rst),
    .ctl (ctl_if)
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  string        name_q[$];
  int           total = 0;
  int           bad = 0;
  logic         end_req = 1'b0;
  logic         done = 1'b0;

  // Strobe-only mask for reset cycles, where the state may be undefined.
  localparam logic [W-1:0] RMASK = {4'b0, 3'b111, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [W-1:0] FULL  = '1;

  function automatic logic [W-1:0] vec(input logic [3:0] st, input logic pcs, input logic regw,
                                       input logic memw, input logic [1:0] fw, input logic np,
                                       input logic irw, input logic adr, input logic asa,
                                       input logic [1:0] asb, input logic [1:0] rs,
                                       input logic [1:0] ac);
    logic [1:0] rsrc;
    rsrc = {ctl_if.op == 2'b01, ctl_if.op == 2'b10};
    return {st, pcs, regw, memw, fw, np, irw, adr, asa, asb, rs, ac, ctl_if.op, rsrc};
  endfunction

  function automatic logic [W-1:0] got_vec();
    return {ctl_if.state, ctl_if.pcs, ctl_if.regw, ctl_if.memw, ctl_if.flagw, ctl_if.nextpc,
            ctl_if.irwrite, ctl_if.adrsrc, ctl_if.alusrca, ctl_if.alusrcb, ctl_if.resultsrc,
            ctl_if.alucontrol, ctl_if.immsrc, ctl_if.regsrc};
  endfunction

  task automatic push(input string nm, input logic [W-1:0] v, input logic [W-1:0] m);
    exp_q.push_back(v);
    mask_q.push_back(m);
    name_q.push_back(nm);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
    ctl_if.op    = op;
    ctl_if.funct = funct;
    ctl_if.rd    = rd;
  endtask

  task automatic push_fd(input string nm);
    push({nm, "_fetch"},  vec(4'd0, 0, 0, 0, 2'b00, 1, 1, 0, 1, 2'b10, 2'b10, 2'b00), FULL);
    push({nm, "_decode"}, vec(4'd1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00), FULL);
  endtask

  task automatic push_ldr_tail(input string nm);
    push({nm, "_memadr"},  vec(4'd2, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00), FULL);
    push({nm, "_memread"}, vec(4'd3, 0, 0, 0, 2'b00, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00), FULL);
    push({nm, "_memwb"},   vec(4'd4, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00), FULL);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, m, g;
      string nm;
      e  = exp_q.pop_front();
      m  = mask_q.pop_front();
      nm = name_q.pop_front();
      g  = got_vec();
      total++;
      if ((g & m) !== (e & m)) begin
        bad++;
        $display("FAIL %s: got=%h want=%h mask=%h", nm, g, e, m);
      end
    end else if (end_req && !done) begin
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL drain: got=%0d leftover want=0", exp_q.size());
      end
      done = 1'b1;
    end
  end

  initial begin
    #20000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    set_instr(2'b00, 6'b000000, 4'd0);
    push("rst_c0", '0, RMASK);
    push("rst_c1", '0, RMASK);
    step(3);
    rst = 1'b0;

    // LDR r4
    set_instr(2'b01, 6'b011001, 4'd4);
    push_fd("ldr");
    push_ldr_tail("ldr");
    step(5);

    // STR
    set_instr(2'b01, 6'b011000, 4'd4);
    push_fd("str");
    push("str_memadr", vec(4'd2, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00), FULL);
    push("str_memwr",  vec(4'd5, 0, 0, 1, 2'b00, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00), FULL);
    step(4);

    // ADDS r3, register operand
    set_instr(2'b00, 6'b001001, 4'd3);
    push_fd("adds3");
    push("adds3_exec",  vec(4'd6, 0, 0, 0, 2'b11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00), FULL);
    push("adds3_aluwb", vec(4'd8, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00), FULL);
    step(4);

    // ADDS r15 -> PC write in ALUWB
    set_instr(2'b00, 6'b001001, 4'd15);
    push_fd("adds15");
    push("adds15_exec",  vec(4'd6, 0, 0, 0, 2'b11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00), FULL);
    push("adds15_aluwb", vec(4'd8, 1, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00), FULL);
    step(4);

    // CMP: three cycles, no register write
    set_instr(2'b00, 6'b010101, 4'd15);
    push_fd("cmp");
    push("cmp_exec", vec(4'd6, 0, 0, 0, 2'b11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01), FULL);
    step(3);

    // ORRS immediate: only NZ flags
    set_instr(2'b00, 6'b111001, 4'd2);
    push_fd("orrs");
    push("orrs_exec",  vec(4'd7, 0, 0, 0, 2'b10, 0, 0, 0, 0, 2'b01, 2'b00, 2'b11), FULL);
    push("orrs_aluwb", vec(4'd8, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00), FULL);
    step(4);

    // SUB without S, AND without S
    set_instr(2'b00, 6'b000100, 4'd1);
    push_fd("sub");
    push("sub_exec",  vec(4'd6, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01), FULL);
    push("sub_aluwb", vec(4'd8, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00), FULL);
    step(4);
    set_instr(2'b00, 6'b000000, 4'd5);
    push_fd("and");
    push("and_exec",  vec(4'd6, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10), FULL);
    push("and_aluwb", vec(4'd8, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00), FULL);
    step(4);

    // Undefined op: straight back to FETCH
    set_instr(2'b11, 6'b001001, 4'd7);
    push_fd("und");
    step(2);

    // Branch
    set_instr(2'b10, 6'b101000, 4'd0);
    push_fd("b");
    push("b_branch", vec(4'd9, 1, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00), FULL);
    step(3);

    // LDR r15 abandoned by reset in MEMREAD, then rerun to completion
    set_instr(2'b01, 6'b011001, 4'd15);
    push_fd("ldrr");
    push("ldrr_memadr", vec(4'd2, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00), FULL);
    step(3);
    rst = 1'b1;
    push("ldrr_rst_memread", vec(4'd3, 0, 0, 0, 2'b00, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00), FULL);
    step(1);
    push("ldrr_rst_fetch", vec(4'd0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00), FULL);
    step(1);
    rst = 1'b0;
    push_fd("ldrr2");
    push("ldrr2_memadr",  vec(4'd2, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00), FULL);
    push("ldrr2_memread", vec(4'd3, 0, 0, 0, 2'b00, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00), FULL);
    push("ldrr2_memwb",   vec(4'd4, 1, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00), FULL);
    step(5);

    end_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    if (!done) begin
      bad++;
      $display("FAIL drain_wait: got=pending want=done");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/control_multicycle_fsm.md
# control_multicycle_fsm

Main controller for the multicycle ARM-subset datapath. Decodes the latched instruction fields, sequences FETCH/DECODE/EXECUTE/WRITEBACK over multiple cycles, and produces the unconditioned strobes `pcs`, `regw`, `memw` and `flagw` that the conditional-execution stage qualifies with `condex`. It also produces the datapath mux selects, the ALU control and the IR/PC enables.

## Interface
Parameters: none. Encodings are fixed in `control_pkg`.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `op`  in  2  instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined
- `funct`  in  6  instr[25:20]: [5] I-bit, [4:1] cmd, [0] S/L bit
- `rd`  in  4  instr[15:12]
- `pcs`  out  1  PC-source request: BRANCH state, or `regw` with `rd`==15
- `regw`  out  1  register-file write request, unconditioned
- `memw`  out  1  data-memory write request, unconditioned
- `flagw`  out  2  [1] NZ update, [0] CV update, unconditioned
- `nextpc`  out  1  unconditional PC+4 write
- `irwrite`  out  1  instruction-register enable
- `adrsrc`  out  1  memory address: 0 PC, 1 ALU result
- `alusrca`  out  1  0 register A, 1 PC
- `alusrcb`  out  2  00 register B, 01 extended imm, 10 constant 4
- `resultsrc`  out  2  00 ALUOut, 01 read data, 10 ALU result
- `alucontrol`  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- `immsrc`  out  2  equals `op`
- `regsrc`  out  2  [0] = (`op`==10), [1] = (`op`==01)
- `state`  out  4  current state, for debug

## Operation
States and transitions:
- FETCH: `irwrite`=1, `nextpc`=1, `adrsrc`=0, `alusrca`=1, `alusrcb`=10, `resultsrc`=10, ADD. Next state is DECODE.
- DECODE: `alusrca`=1, `alusrcb`=10, `resultsrc`=10, ADD.
  - `op`=01 goes to MEMADR.
  - `op`=00 with `funct`[5]=0 goes to EXECR.
  - `op`=00 with `funct`[5]=1 goes to EXECI.
  - `op`=10 goes to BRANCH.
  - `op`=11 goes to FETCH with no strobes.
- MEMADR: `alusrca`=0, `alusrcb`=01, ADD. `funct`[0]=1 goes to MEMREAD; otherwise goes to MEMWRITE.
- MEMREAD: `adrsrc`=1, `resultsrc`=00. Next state is MEMWB.
- MEMWB: `resultsrc`=01, `regw`=1. Next state is FETCH.
- MEMWRITE: `adrsrc`=1, `memw`=1. Next state is FETCH.
- EXECR: `alusrca`=0, `alusrcb`=00, ALU decoded. EXECI is identical except `alusrcb`=01.
  - From either state, CMP goes to FETCH.
  - Any other command goes to ALUWB.
- ALUWB: `resultsrc`=00, `regw`=1. Next state is FETCH.
- BRANCH: `alusrca`=0, `alusrcb`=01, `resultsrc`=10, ADD, `pcs`=1. Next state is FETCH.

ALU decode (applies only in EXECR/EXECI; every other state forces ADD and `flagw`=00):
- `funct`[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB).
- Any other cmd gives ADD with `flagw`=00.
- `flagw`[1] = `funct`[0]. `flagw`[0] = `funct`[0] AND (ADD or SUB).
- CMP forces `flagw`=11 regardless of S, and skips ALUWB, so it never writes a register.

Outputs and reset:
- All outputs are Moore outputs decoded from `state` and the instruction fields; no output registers.
- The only `pcs` sources are BRANCH and a register write with `rd`==15 (MEMWB or ALUWB). In every other state `pcs`=0.
- While `rst`=1, the strobes `irwrite`, `nextpc`, `regw`, `memw`, `pcs` and `flagw` are forced to 0.
- On a `clk` edge with `rst`=1, `state` becomes FETCH.

## Timing
- Cycles per instruction: LDR 5, STR 4, data-processing 4, CMP 3, B 3, undefined 2.
- Reset mid-instruction: the instruction is abandoned at the edge. No further `regw`/`memw` is issued, and the first cycle after deassertion is FETCH with `irwrite`=1.
- `op`, `funct` and `rd` come from the IR and are stable from DECODE until the next FETCH. The block samples them only through the state decode.
- `flagw` is asserted for exactly one cycle per flag-setting instruction, aligned with the ALU operation.

## Structure
- `control_pkg` holds:
  - the `state_t` enum: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9
  - the ALU control constants
  - the `op` and cmd encodings
- Sub-module `control_alu_decoder`: combinational map from `funct` and an `aluop` enable to `alucontrol`, `flagw` and an `nowrite` (CMP) flag.
- The top level contains the state register, the next-state logic and the output decode.

## Test plan
- Reset: `rst`=1 for 2 cycles, then 0 -> all strobes 0 during reset; first post-reset cycle `state`=FETCH with `irwrite`=1 and `nextpc`=1.
- LDR (`op`=01, `funct`=011001) -> states 0,1,2,3,4; `regw`=1 only in MEMWB with `resultsrc`=01; `memw` never set.
- STR (`funct`=011000) -> states 0,1,2,5; `memw`=1 for one cycle with `adrsrc`=1; `regw` stays 0.
- ADDS with register operand (`op`=00, `funct`=001001, `rd`=3) -> EXECR with `alucontrol`=00 and `flagw`=11, then ALUWB with `regw`=1 and `pcs`=0. Repeat with `rd`=15 -> `pcs`=1 in ALUWB.
- CMP (`funct`=010101) -> states 0,1,6,0; `alucontrol`=01, `flagw`=11, `regw` never set.
- B (`op`=10) -> BRANCH with `pcs`=1, then FETCH. Assert `rst` during MEMREAD of an LDR -> no `regw`, restart at FETCH.
